// File: rtl/sprite_anim_mapper.sv
// Animated sprite to ROM address mapper with a fixed 3-cycle pixel pipeline.
// Define SPRITE_TRANSP_EN to treat palette index TRANSP_IDX as transparent.
module sprite_anim_mapper #(
    parameter int SPR_W      = 21,
    parameter int SPR_H      = 45,
    parameter int SCALE_LOG2 = 0,
    parameter int NUM_FRAMES = 4,
    parameter int FRAME_HOLD = 8,
    parameter int ADDR_W     = 12,
    parameter int IDX_W      = 5,
    parameter int TRANSP_IDX = 0
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic              frame_start,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic              flip,
    input  logic              anim_en,
    input  logic              anim_restart,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [IDX_W-1:0]  rom_q,
    output logic [IDX_W-1:0]  pix_idx,
    output logic              pix_hit
);

    localparam int FRAME_SZ = SPR_W * SPR_H;
    localparam int CNT_W = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
    localparam int FRM_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam logic [10:0] BOX_W = 11'(SPR_W << SCALE_LOG2);
    localparam logic [10:0] BOX_H = 11'(SPR_H << SCALE_LOG2);
    localparam logic [IDX_W-1:0] TKEY = IDX_W'(TRANSP_IDX);
`ifdef SPRITE_TRANSP_EN
    localparam bit TRANSP_EN = 1'b1;
`else
    localparam bit TRANSP_EN = 1'b0;
`endif

    logic [9:0]        sx;
    logic [9:0]        sy;
    logic              sflip;
    logic [CNT_W-1:0]  cnt;
    logic [FRM_W-1:0]  frame;

    logic              inbox;
    logic [10:0]       ox;
    logic [10:0]       oy;
    logic [10:0]       lx_raw;
    logic [10:0]       lx;
    logic [10:0]       ly;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] addr_n;

    logic              inbox_d1;
    logic              inbox_d2;
    logic              blank_d1;
    logic              blank_d2;
    logic              opaque;

    // Shadow position and animation state only move on frame boundaries
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            sx    <= '0;
            sy    <= '0;
            sflip <= 1'b0;
            cnt   <= '0;
            frame <= '0;
        end else begin
            if (frame_start) begin
                sx    <= pos_x;
                sy    <= pos_y;
                sflip <= flip;
            end
            if (anim_restart) begin
                cnt   <= '0;
                frame <= '0;
            end else if (frame_start && anim_en) begin
                if (cnt == CNT_W'(FRAME_HOLD - 1)) begin
                    cnt   <= '0;
                    frame <= (frame == FRM_W'(NUM_FRAMES - 1)) ?
                             '0 : frame + 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        ox     = {1'b0, DrawX} - {1'b0, sx};
        oy     = {1'b0, DrawY} - {1'b0, sy};
        inbox  = ({1'b0, DrawX} >= {1'b0, sx}) &&
                 ({1'b0, DrawX} < ({1'b0, sx} + BOX_W)) &&
                 ({1'b0, DrawY} >= {1'b0, sy}) &&
                 ({1'b0, DrawY} < ({1'b0, sy} + BOX_H));
        lx_raw = ox >> SCALE_LOG2;
        ly     = oy >> SCALE_LOG2;
        lx     = sflip ? (11'(SPR_W - 1) - lx_raw) : lx_raw;
        base   = ADDR_W'(32'(frame) * 32'(FRAME_SZ));
        addr_n = base;
        if (inbox)
            addr_n = base + ADDR_W'(32'(ly) * 32'(SPR_W) + 32'(lx));
    end

    assign opaque = !TRANSP_EN || (rom_q != TKEY);

    // Flags trail the ROM read so they line up with rom_q
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            rom_address <= '0;
            inbox_d1    <= 1'b0;
            inbox_d2    <= 1'b0;
            blank_d1    <= 1'b0;
            blank_d2    <= 1'b0;
            pix_idx     <= '0;
            pix_hit     <= 1'b0;
        end else begin
            rom_address <= addr_n;
            inbox_d1    <= inbox;
            blank_d1    <= blank;
            inbox_d2    <= inbox_d1;
            blank_d2    <= blank_d1;
            pix_idx     <= rom_q;
            pix_hit     <= inbox_d2 && blank_d2 && opaque;
        end
    end

endmodule

// File: tb/tb_sprite_anim_mapper.sv
// Scoreboard bench for sprite_anim_mapper with a synchronous ROM model.
module tb_sprite_anim_mapper;

    localparam int AW = 12;
    localparam int IW = 5;
`ifdef SPRITE_TRANSP_EN
    localparam bit TEN = 1'b1;
`else
    localparam bit TEN = 1'b0;
`endif

    logic          vga_clk = 1'b0;
    logic          reset = 1'b1;
    logic [9:0]    DrawX = '0;
    logic [9:0]    DrawY = '0;
    logic          blank = 1'b0;
    logic          frame_start = 1'b0;
    logic [9:0]    pos_x = '0;
    logic [9:0]    pos_y = '0;
    logic          flip = 1'b0;
    logic          anim_en = 1'b0;
    logic          anim_restart = 1'b0;
    logic [AW-1:0] rom_address;
    logic [IW-1:0] rom_q = '0;
    logic [IW-1:0] pix_idx;
    logic          pix_hit;

    always #5 vga_clk = ~vga_clk;

    sprite_anim_mapper #(
        .SPR_W(21), .SPR_H(45), .SCALE_LOG2(1), .NUM_FRAMES(4),
        .FRAME_HOLD(2), .ADDR_W(AW), .IDX_W(IW), .TRANSP_IDX(0)
    ) dut (
        .vga_clk(vga_clk), .reset(reset),
        .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .frame_start(frame_start),
        .pos_x(pos_x), .pos_y(pos_y), .flip(flip),
        .anim_en(anim_en), .anim_restart(anim_restart),
        .rom_address(rom_address), .rom_q(rom_q),
        .pix_idx(pix_idx), .pix_hit(pix_hit)
    );

    logic [IW-1:0] rom_mem [4096];
    always @(posedge vga_clk) rom_q <= rom_mem[rom_address];

    int cyc = 0;
    always @(posedge vga_clk) cyc <= cyc + 1;

    typedef struct {
        int            due;
        int            addr;
        logic          hit;
        logic [IW-1:0] idx;
        bit            chk_idx;
        string         nm;
    } exp_t;

    exp_t aq[$];
    exp_t pq[$];
    int total = 0;
    int bad = 0;

    function automatic logic opq(input logic [IW-1:0] v);
        return (v != '0) || !TEN;
    endfunction

    always @(negedge vga_clk) begin : mon
        exp_t e;
        while (aq.size() > 0 && aq[0].due <= cyc) begin
            e = aq.pop_front();
            total++;
            if (e.due != cyc) begin
                bad++;
                $display("FAIL %s addr: missed check due %0d at %0d",
                         e.nm, e.due, cyc);
            end else if (rom_address !== AW'(e.addr)) begin
                bad++;
                $display("FAIL %s addr: got %0d want %0d",
                         e.nm, rom_address, e.addr);
            end
        end
        while (pq.size() > 0 && pq[0].due <= cyc) begin
            e = pq.pop_front();
            total++;
            if (e.due != cyc) begin
                bad++;
                $display("FAIL %s pix: missed check due %0d at %0d",
                         e.nm, e.due, cyc);
            end else if (pix_hit !== e.hit ||
                         (e.chk_idx && pix_idx !== e.idx)) begin
                bad++;
                $display("FAIL %s pix: got hit=%0b idx=%0d want hit=%0b idx=%0d",
                         e.nm, pix_hit, pix_idx, e.hit, e.idx);
            end
        end
    end

    task automatic push_addr(input string nm, input int due, input int ea);
        exp_t e;
        e.due = due; e.addr = ea; e.hit = 1'b0;
        e.idx = '0; e.chk_idx = 1'b0; e.nm = nm;
        aq.push_back(e);
    endtask

    task automatic push_pix(input string nm, input int due, input logic h,
                            input logic [IW-1:0] v, input bit ci);
        exp_t e;
        e.due = due; e.addr = 0; e.hit = h;
        e.idx = v; e.chk_idx = ci; e.nm = nm;
        pq.push_back(e);
    endtask

    task automatic probe(input string nm, input int x, input int y,
                         input logic b, input logic inb, input int ea);
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank = b;
        push_addr(nm, cyc + 1, ea);
        push_pix(nm, cyc + 3, inb & b & opq(rom_mem[ea]), rom_mem[ea], 1'b1);
        @(negedge vga_clk);
    endtask

    task automatic pulse(input bit rst);
        DrawX = '0;
        DrawY = '0;
        blank = 1'b0;
        frame_start = 1'b1;
        anim_restart = rst;
        @(negedge vga_clk);
        frame_start = 1'b0;
        anim_restart = 1'b0;
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) pulse(1'b0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom_mem[i] = IW'((i % 31) + 1);
        rom_mem[20]  = 5'd3;
        rom_mem[115] = 5'd0;

        push_addr("reset0", 1, 0);
        push_pix("reset0", 1, 1'b0, '0, 1'b1);
        @(negedge vga_clk);
        reset = 1'b0;
        pos_x = 10'd100;
        pos_y = 10'd50;
        pulse(1'b0);

        probe("origin",      100,  50, 1'b1, 1'b1,   0);
        probe("right_edge",  141,  50, 1'b1, 1'b1,  20);
        probe("past_right",  142,  50, 1'b1, 1'b0,   0);
        probe("left_out",     99,  50, 1'b1, 1'b0,   0);
        probe("bottom",      100, 139, 1'b1, 1'b1, 924);
        probe("past_bottom", 100, 140, 1'b1, 1'b0,   0);
        probe("transp",      120,  60, 1'b1, 1'b1, 115);
        probe("blank0",      100,  50, 1'b0, 1'b1,   0);

        flip = 1'b1;
        pulse(1'b0);
        probe("flip_l", 100, 52, 1'b1, 1'b1, 41);
        probe("flip_r", 141, 50, 1'b1, 1'b1,  0);

        flip = 1'b0;
        anim_en = 1'b1;
        pulse(1'b0);
        probe("hold1", 100, 50, 1'b1, 1'b1, 0);
        pulse(1'b0);
        probe("f1",  100, 50, 1'b1, 1'b1, 945);
        probe("f1r", 141, 50, 1'b1, 1'b1, 965);

        anim_en = 1'b0;
        pulses(3);
        probe("en0", 100, 50, 1'b1, 1'b1, 945);

        anim_en = 1'b1;
        pulses(2);
        probe("f2", 100, 50, 1'b1, 1'b1, 1890);
        pulses(4);
        probe("wrap", 100, 50, 1'b1, 1'b1, 0);

        pulses(3);
        probe("pre_rst", 100, 50, 1'b1, 1'b1, 945);
        pos_x = 10'd110;
        pulse(1'b1);
        probe("restart", 151, 50, 1'b1, 1'b1, 20);
        probe("old_x",   100, 50, 1'b1, 1'b0,  0);
        pulse(1'b0);
        probe("rst_cnt", 151, 50, 1'b1, 1'b1, 20);
        pulse(1'b0);
        probe("after_rst", 151, 50, 1'b1, 1'b1, 965);

        anim_en = 1'b0;
        pos_x = 10'd200;
        probe("mid_frame", 151, 50, 1'b1, 1'b1, 965);
        pulse(1'b0);
        probe("new_x",   241, 50, 1'b1, 1'b1, 965);
        probe("old_out", 151, 50, 1'b1, 1'b0, 945);

        anim_en = 1'b1;
        pulses(2);
        probe("f2b", 241, 50, 1'b1, 1'b1, 1910);
        anim_en = 1'b0;

        DrawX = 10'd241;
        DrawY = 10'd50;
        blank = 1'b1;
        repeat (4) @(negedge vga_clk);
        reset = 1'b1;
        push_addr("reset1", cyc + 1, 0);
        push_pix("reset1", cyc + 1, 1'b0, '0, 1'b1);
        @(negedge vga_clk);
        reset = 1'b0;
        push_pix("rel_c1", cyc + 1, 1'b0, '0, 1'b0);
        push_pix("rel_c2", cyc + 2, 1'b0, '0, 1'b0);
        probe("rel_first", 0, 0, 1'b1, 1'b1, 0);
        probe("post_rst", 41, 0, 1'b1, 1'b1, 20);

        for (int i = 0; i < 20 && (aq.size() > 0 || pq.size() > 0); i++)
            @(negedge vga_clk);
        if (aq.size() > 0 || pq.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d checks pending, want 0",
                     aq.size() + pq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
